// File: rtl/inference_tile_scheduler_if.sv
// rtl/inference_tile_scheduler_if.sv - host/datapath handshake bundle for inference_tile_scheduler
interface inference_tile_scheduler_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  wt_valid;
    logic                  wt_ready;
    logic                  weight_valid;
    logic                  act_valid;
    logic                  act_ready;
    logic                  act_wr_en;
    logic [ADDR_WIDTH-1:0] act_wr_addr;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  acc_wr_en;
    logic [ADDR_WIDTH-1:0] acc_wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  wt_valid, act_valid, out_ready,
        output wt_ready, weight_valid, act_ready, act_wr_en, act_wr_addr,
               read_addr, acc_wr_en, acc_wr_addr, rd_addr, out_valid
    );

    modport master (
        output wt_valid, act_valid, out_ready,
        input  wt_ready, weight_valid, act_ready, act_wr_en, act_wr_addr,
               read_addr, acc_wr_en, acc_wr_addr, rd_addr, out_valid
    );
endinterface

// File: rtl/inference_tile_scheduler.sv
// rtl/inference_tile_scheduler.sv - five-phase normal-mode tile sequencer; SCHED_PERF_CNT_EN enables cycle_count
module inference_tile_scheduler #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int DRAIN_CYCLES  = 2 * SYSTOLIC_SIZE,
    parameter int RD_LATENCY    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              test_mode,
    input  logic                              start,
    input  logic                              recovery_done,
    input  logic                              recovery_success,
    inference_tile_scheduler_if.slave         bus,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [31:0]                       cycle_count
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int LW = $clog2(RD_LATENCY + 2);
    localparam logic [CW-1:0] ROW_LAST   = CW'(SYSTOLIC_SIZE - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_WR   = DW'(DRAIN_CYCLES - SYSTOLIC_SIZE);
    localparam logic [LW-1:0] LAT        = LW'(RD_LATENCY);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_RECOV, S_LOAD_W, S_LOAD_A, S_COMPUTE,
        S_DRAIN, S_READOUT, S_DONE, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         row_q, row_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic                  error_q, error_d;
    logic                  wt_ready_q, wt_ready_d;
    logic                  act_ready_q, act_ready_d;
    logic [ADDR_WIDTH-1:0] act_wr_addr_q, act_wr_addr_d;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic                  acc_wr_en_q, acc_wr_en_d;
    logic [ADDR_WIDTH-1:0] acc_wr_addr_q, acc_wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drain_d = drain_q;
        lat_d   = lat_q;
        error_d = error_q;
        if (test_mode) begin
            state_d = S_IDLE;
            row_d   = '0;
            drain_d = '0;
            lat_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state_d = S_WAIT_RECOV;
                        error_d = 1'b0;
                    end
                end
                S_WAIT_RECOV: begin
                    if (recovery_done && recovery_success) begin
                        state_d = S_LOAD_W;
                    end else if (recovery_done) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
                S_LOAD_W: begin
                    if (bus.wt_valid && wt_ready_q) begin
                        if (row_q == ROW_LAST) begin
                            state_d = S_LOAD_A;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end
                end
                S_LOAD_A: begin
                    if (bus.act_valid && act_ready_q) begin
                        if (row_q == ROW_LAST) begin
                            state_d = S_COMPUTE;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (row_q == ROW_LAST) begin
                        state_d = S_DRAIN;
                        row_d   = '0;
                        drain_d = '0;
                    end else begin
                        row_d = row_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = S_READOUT;
                        drain_d = '0;
                        row_d   = '0;
                        lat_d   = '0;
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
                S_READOUT: begin
                    // A row retires only on a real handshake; early out_ready is ignored.
                    if (out_valid_q && bus.out_ready) begin
                        lat_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DONE;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else if (lat_q != LAT) begin
                        lat_d = lat_q + LW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so every one of them leaves a flop.
        wt_ready_d    = (state_d == S_LOAD_W);
        act_ready_d   = (state_d == S_LOAD_A);
        act_wr_addr_d = act_ready_d ? row_d[ADDR_WIDTH-1:0] : '0;
        read_addr_d   = (state_d == S_COMPUTE) ? row_d[ADDR_WIDTH-1:0] : '0;
        acc_wr_en_d   = (state_d == S_DRAIN) && (drain_d >= DRAIN_WR);
        acc_wr_addr_d = acc_wr_en_d ? ADDR_WIDTH'(drain_d - DRAIN_WR) : '0;
        rd_addr_d     = (state_d == S_READOUT) ? row_d[ADDR_WIDTH-1:0] : '0;
        out_valid_d   = (state_d == S_READOUT) && (lat_d == LAT);
        busy_d        = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            drain_q       <= '0;
            lat_q         <= '0;
            error_q       <= 1'b0;
            wt_ready_q    <= 1'b0;
            act_ready_q   <= 1'b0;
            act_wr_addr_q <= '0;
            read_addr_q   <= '0;
            acc_wr_en_q   <= 1'b0;
            acc_wr_addr_q <= '0;
            rd_addr_q     <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            drain_q       <= drain_d;
            lat_q         <= lat_d;
            error_q       <= error_d;
            wt_ready_q    <= wt_ready_d;
            act_ready_q   <= act_ready_d;
            act_wr_addr_q <= act_wr_addr_d;
            read_addr_q   <= read_addr_d;
            acc_wr_en_q   <= acc_wr_en_d;
            acc_wr_addr_q <= acc_wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.wt_ready     = wt_ready_q;
    assign bus.weight_valid = bus.wt_valid & wt_ready_q;
    assign bus.act_ready    = act_ready_q;
    assign bus.act_wr_en    = bus.act_valid & act_ready_q;
    assign bus.act_wr_addr  = act_wr_addr_q;
    assign bus.read_addr    = read_addr_q;
    assign bus.acc_wr_en    = acc_wr_en_q;
    assign bus.acc_wr_addr  = acc_wr_addr_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.out_valid    = out_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

`ifdef SCHED_PERF_CNT_EN
    logic        start_accept;
    logic [31:0] cycle_count_q, cycle_count_d;

    assign start_accept = start && !test_mode && (state_q == S_IDLE || state_q == S_ERR);

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (start_accept) begin
            cycle_count_d = '0;
        end else if (busy_q && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = 32'd0;
`endif
endmodule

// File: tb/tb_inference_tile_scheduler.sv
// tb/tb_inference_tile_scheduler.sv - scoreboard bench for inference_tile_scheduler
module tb_inference_tile_scheduler;
    localparam int S  = 8;
    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        test_mode;
    logic        start;
    logic        recovery_done;
    logic        recovery_success;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;
    int exp_act[$];
    int exp_read[$];
    int exp_acc[$];
    int exp_rd[$];

    inference_tile_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    inference_tile_scheduler #(.SYSTOLIC_SIZE(S)) dut (
        .clk              (clk),
        .rst              (rst),
        .test_mode        (test_mode),
        .start            (start),
        .recovery_done    (recovery_done),
        .recovery_success (recovery_success),
        .bus              (bus),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .cycle_count      (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1; test_mode = 0; start = 0; recovery_done = 0; recovery_success = 0;
        bus.wt_valid = 1; bus.act_valid = 1; bus.out_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, error, bus.wt_ready, bus.weight_valid, bus.act_ready, bus.act_wr_en,
             bus.acc_wr_en, bus.out_valid} !== 9'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0", {busy, done, error, bus.wt_ready,
                bus.weight_valid, bus.act_ready, bus.act_wr_en, bus.acc_wr_en, bus.out_valid});
        end
        checks++;
        if ({bus.act_wr_addr, bus.read_addr, bus.acc_wr_addr, bus.rd_addr} !== 12'b0) begin
            errors++; $display("FAIL reset_addrs got %h exp 0",
                {bus.act_wr_addr, bus.read_addr, bus.acc_wr_addr, bus.rd_addr});
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            errors++; $display("FAIL reset_cycle_count got %0d exp 0", cycle_count);
        end
        @(negedge clk);
        rst = 0; bus.wt_valid = 0; bus.act_valid = 0; bus.out_ready = 0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle busy got %0b exp 0", busy);
        end
    endtask

    // abort: 0 none, 1 test_mode in DRAIN cycle 5, 2 rst during READOUT row 3
    task automatic run_tile(input int wt_gap, input int out_gap, input bit glitch, input int abort);
        int n_wt, n_act, n_out, c_idx, cyc, hold, wt_stall, last_hs, e;
        bit g_act, g_out, finished;
        n_wt = 0; n_act = 0; n_out = 0; c_idx = -1; cyc = 0; hold = 0; wt_stall = 0;
        last_hs = -10; g_act = 0; g_out = 0; finished = 0;
        exp_act.delete(); exp_read.delete(); exp_acc.delete(); exp_rd.delete();
        for (int i = 0; i < S; i++) begin
            exp_act.push_back(i); exp_read.push_back(i); exp_acc.push_back(i); exp_rd.push_back(i);
        end
        @(negedge clk);
        rst = 0; test_mode = 0; start = 1; recovery_done = 0; recovery_success = 1;
        bus.wt_valid = 1; bus.act_valid = 1; bus.out_ready = 1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", busy); end
        @(negedge clk);
        start = 0; recovery_done = 1; cyc = 1;
        #1;
        checks++;
        if ({busy, error, bus.wt_ready} !== 3'b100) begin
            errors++; $display("FAIL wait_recov busy/error/wt_ready got %b exp 100",
                {busy, error, bus.wt_ready});
        end
        while (!finished && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = 0;
            bus.wt_valid  = !(n_wt == 2 && wt_stall < wt_gap);
            bus.out_ready = !(n_out == 4 && hold < out_gap);
            if (glitch && !g_act && n_act == 3) begin start = 1; g_act = 1; end
            if (glitch && !g_out && n_out == 2) begin start = 1; g_out = 1; end
            if (abort == 1 && c_idx == 13) test_mode = 1;
            if (abort == 2 && n_out == 3) rst = 1;
            #1;
            checks++;
            if (bus.wt_ready !== (n_wt < S)) begin
                errors++; $display("FAIL wt_ready cyc %0d got %0b exp %0b", cyc, bus.wt_ready, n_wt < S);
            end
            checks++;
            if (bus.weight_valid !== ((n_wt < S) && bus.wt_valid)) begin
                errors++; $display("FAIL weight_valid cyc %0d rows %0d got %0b", cyc, n_wt, bus.weight_valid);
            end
            if (!bus.wt_valid && n_wt == 2) wt_stall++;
            if (bus.weight_valid) n_wt++;
            checks++;
            if (bus.act_wr_en !== (n_wt == S && n_act < S && !bus.weight_valid)) begin
                errors++; $display("FAIL act_wr_en cyc %0d got %0b", cyc, bus.act_wr_en);
            end
            if (bus.act_wr_en) begin
                checks++;
                if (exp_act.size() == 0) begin
                    errors++; $display("FAIL act_extra_row cyc %0d got addr %0d exp none", cyc, bus.act_wr_addr);
                end else begin
                    e = exp_act.pop_front();
                    if (32'(bus.act_wr_addr) !== e) begin
                        errors++; $display("FAIL act_wr_addr got %0d exp %0d", bus.act_wr_addr, e);
                    end
                end
                n_act++;
            end
            if (c_idx < 0 || c_idx >= 24) begin
                checks++;
                if ({bus.acc_wr_en, bus.read_addr} !== 4'b0) begin
                    errors++; $display("FAIL idle_compute cyc %0d acc_wr_en %0b read_addr %0d exp 0 0",
                        cyc, bus.acc_wr_en, bus.read_addr);
                end
            end else begin
                if (c_idx < S) begin
                    e = exp_read.pop_front();
                end else begin
                    e = 0;
                end
                checks++;
                if (32'(bus.read_addr) !== e) begin
                    errors++; $display("FAIL read_addr idx %0d got %0d exp %0d", c_idx, bus.read_addr, e);
                end
                checks++;
                if (bus.acc_wr_en !== (c_idx >= 16)) begin
                    errors++; $display("FAIL acc_wr_en idx %0d got %0b exp %0b", c_idx, bus.acc_wr_en, c_idx >= 16);
                end
                if (c_idx >= 16) begin
                    e = exp_acc.pop_front();
                    checks++;
                    if (32'(bus.acc_wr_addr) !== e) begin
                        errors++; $display("FAIL acc_wr_addr got %0d exp %0d", bus.acc_wr_addr, e);
                    end
                end
            end
            if (c_idx < 24 || c_idx == 24) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++; $display("FAIL out_valid_early idx %0d got 1 exp 0", c_idx);
                end
            end
            if (c_idx == 25) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL out_valid_latency got %0b exp 1", bus.out_valid);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                hold++;
                checks++;
                if (32'(bus.rd_addr) !== n_out) begin
                    errors++; $display("FAIL rd_addr_hold got %0d exp %0d", bus.rd_addr, n_out);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++; $display("FAIL out_extra_row got addr %0d exp none", bus.rd_addr);
                end else begin
                    e = exp_rd.pop_front();
                    if (32'(bus.rd_addr) !== e) begin
                        errors++; $display("FAIL rd_addr got %0d exp %0d", bus.rd_addr, e);
                    end
                end
                n_out++;
                last_hs = cyc;
            end
            if (done) begin
                finished = 1;
                checks++;
                if (n_out != S || last_hs != cyc - 1 || busy !== 1'b0) begin
                    errors++; $display("FAIL done_timing rows %0d last_hs %0d cyc %0d busy %0b exp rows %0d",
                        n_out, last_hs, cyc, busy, S);
                end
`ifdef SCHED_PERF_CNT_EN
                checks++;
                if (cycle_count !== 32'(cyc - 1)) begin
                    errors++; $display("FAIL cycle_count got %0d exp %0d", cycle_count, cyc - 1);
                end
`else
                checks++;
                if (cycle_count !== 32'd0) begin
                    errors++; $display("FAIL cycle_count got %0d exp 0", cycle_count);
                end
`endif
            end
            if (c_idx >= 0) c_idx++;
            else if (n_act == S) c_idx = 0;
            if (test_mode || rst) break;
        end
        if (abort == 0) begin
            checks++;
            if (!finished) begin errors++; $display("FAIL tile_timeout got no done exp done within 600 cycles"); end
            checks++;
            if (n_wt != S || n_act != S || exp_read.size() != 0 || exp_acc.size() != 0) begin
                errors++; $display("FAIL row_counts wt %0d act %0d read_left %0d acc_left %0d exp %0d %0d 0 0",
                    n_wt, n_act, exp_read.size(), exp_acc.size(), S, S);
            end
            if (wt_gap > 0) begin
                checks++;
                if (wt_stall != wt_gap) begin
                    errors++; $display("FAIL wt_stall_cycles got %0d exp %0d", wt_stall, wt_gap);
                end
            end
            if (out_gap > 0) begin
                checks++;
                if (hold != out_gap) begin
                    errors++; $display("FAIL out_hold_cycles got %0d exp %0d", hold, out_gap);
                end
            end
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL done_single_pulse done %0b busy %0b exp 0 0", done, busy);
            end
        end else if (abort == 1) begin
            checks++;
            if (test_mode !== 1'b1) begin errors++; $display("FAIL abort_not_reached got none exp test_mode"); end
            @(negedge clk);
            #1;
            checks++;
            if ({busy, done, bus.acc_wr_en, bus.out_valid, bus.wt_ready, bus.act_ready} !== 6'b0) begin
                errors++; $display("FAIL test_mode_idle got %b exp 0",
                    {busy, done, bus.acc_wr_en, bus.out_valid, bus.wt_ready, bus.act_ready});
            end
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1;
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("FAIL test_mode_no_done done %0b busy %0b exp 0 0", done, busy);
                end
            end
            test_mode = 0;
        end else begin
            checks++;
            if (rst !== 1'b1) begin errors++; $display("FAIL rst_not_reached got none exp rst"); end
            @(negedge clk);
            rst = 0;
            #1;
            checks++;
            if ({busy, done, error, bus.wt_ready, bus.weight_valid, bus.act_ready, bus.act_wr_en,
                 bus.acc_wr_en, bus.out_valid, bus.act_wr_addr, bus.read_addr, bus.acc_wr_addr,
                 bus.rd_addr} !== 21'b0 || cycle_count !== 32'd0) begin
                errors++; $display("FAIL rst_mid_tile outputs not zero busy %0b out_valid %0b rd_addr %0d cycle_count %0d",
                    busy, bus.out_valid, bus.rd_addr, cycle_count);
            end
        end
    endtask

    task automatic test_nominal();
        run_tile(0, 0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_tile(3, 5, 1'b0, 0);
    endtask

    task automatic test_recovery_fail();
        @(negedge clk);
        start = 1; recovery_done = 0; recovery_success = 0; bus.wt_valid = 1;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            start = 0; recovery_done = 1;
            #1;
            checks++;
            if (busy !== 1'b1 || error !== 1'b0) begin
                errors++; $display("FAIL recov_wait pass %0d busy %0b error %0b exp 1 0", pass, busy, error);
            end
            @(negedge clk);
            recovery_done = 0;
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({error, busy, bus.wt_ready, bus.weight_valid} !== 4'b1000) begin
                    errors++; $display("FAIL err_state pass %0d got %b exp 1000", pass,
                        {error, busy, bus.wt_ready, bus.weight_valid});
                end
                @(negedge clk);
                #1;
            end
            if (pass == 0) start = 1;
        end
        test_mode = 1;
        @(negedge clk);
        test_mode = 0;
        #1;
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL test_mode_keeps_error error %0b busy %0b exp 1 0", error, busy);
        end
        bus.wt_valid = 0;
    endtask

    task automatic test_test_mode_abort();
        run_tile(0, 0, 1'b0, 1);
        run_tile(0, 0, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        run_tile(0, 0, 1'b1, 0);
    endtask

    task automatic test_reset_mid();
        run_tile(0, 0, 1'b0, 2);
        run_tile(0, 0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_recovery_fail();
        test_test_mode_abort();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
